// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-ported, fixed-latency memory.
// Instruction fetch and data ports share the memory; contention alternates grants.
module mem_port_arbiter #(
    parameter int WORD_SIZE   = 16,
    parameter int MEM_LATENCY = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 i_readM,
    input  logic [WORD_SIZE-1:0] i_address,
    output logic [WORD_SIZE-1:0] i_data,
    output logic                 i_ready,
    input  logic                 d_readM,
    input  logic                 d_writeM,
    input  logic [WORD_SIZE-1:0] d_address,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 m_readM,
    output logic                 m_writeM,
    output logic [WORD_SIZE-1:0] m_address,
    output logic [WORD_SIZE-1:0] m_wdata,
    input  logic [WORD_SIZE-1:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);
    localparam logic       GRANT_I    = 1'b0;
    localparam logic       GRANT_D    = 1'b1;

    state_t                 state, state_next;
    logic [3:0]             cnt;
    logic                   last_grant;
    logic                   op_write;
    logic [WORD_SIZE-1:0]   addr_q;
    logic [WORD_SIZE-1:0]   wdata_q;
    logic                   d_req, grant_i, grant_d, done;
    logic                   busy_i, busy_d;

    // Data side wins a tie only when the instruction side had the previous grant.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        d_req      = d_readM | d_writeM;
        done       = (cnt == 4'd0);
        case (state)
            IDLE: begin
                if (d_req && (!i_readM || last_grant == GRANT_I)) begin
                    grant_d    = 1'b1;
                    state_next = D_BUSY;
                end else if (i_readM) begin
                    grant_i    = 1'b1;
                    state_next = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            cnt        <= 4'd0;
            last_grant <= GRANT_I;
            op_write   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (grant_d) begin
            cnt        <= LAT_M1;
            last_grant <= GRANT_D;
            op_write   <= d_writeM;
            addr_q     <= d_address;
            wdata_q    <= d_wdata;
        end else if (grant_i) begin
            cnt        <= LAT_M1;
            last_grant <= GRANT_I;
            addr_q     <= i_address;
        end else if (state != IDLE && !done) begin
            cnt        <= cnt - 4'd1;
        end
    end

    // Memory controls come straight from registered state so they stay glitch-free for the access.
    always_comb begin
        busy_i    = (state == I_BUSY);
        busy_d    = (state == D_BUSY);
        m_readM   = busy_i | (busy_d & ~op_write);
        m_writeM  = busy_d & op_write;
        m_address = (busy_i | busy_d) ? addr_q : '0;
        m_wdata   = busy_d ? wdata_q : '0;
        i_ready   = busy_i & done;
        d_ready   = busy_d & done;
        i_data    = i_ready ? m_rdata : '0;
        d_rdata   = (d_ready & ~op_write) ? m_rdata : '0;
    end

endmodule
